// File: rtl/sram_serial_streamer.sv
// SRAM readback streamer: reads words from SRAM and shifts them out
// MSB first on a divided SPI-style serial clock.
module sram_serial_streamer #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 5,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  input  logic [DATA_W-1:0] sram_q,
  output logic              ser_clk,
  output logic              ser_mosi,
  output logic              ser_cs_n,
  output logic              busy,
  output logic              done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE, READ, CAPT, SHIFT, NEXT, DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] sreg;
  logic              sclk;
  logic [DIV_W-1:0]  div;
  logic [BIT_W-1:0]  bits;
  logic              half_end;
  logic              last_fall;

  assign half_end  = (div == DIV_W'(CLK_DIV - 1));
  assign last_fall = half_end && sclk &&
                     (bits == BIT_W'(DATA_W - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    sram_cen = 1'b1;
    ser_cs_n = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (word_count == '0) ? DONE : READ;
      end
      READ: begin
        sram_cen = 1'b0;
        ser_cs_n = 1'b0;
        busy     = 1'b1;
        state_nx = CAPT;
      end
      CAPT: begin
        ser_cs_n = 1'b0;
        busy     = 1'b1;
        state_nx = SHIFT;
      end
      SHIFT: begin
        ser_cs_n = 1'b0;
        busy     = 1'b1;
        if (last_fall) state_nx = NEXT;
      end
      NEXT: begin
        ser_cs_n = 1'b0;
        busy     = 1'b1;
        state_nx = (cnt == CNT_W'(1)) ? DONE : READ;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr <= '0;
      cnt  <= '0;
      sreg <= '0;
      sclk <= 1'b0;
      div  <= '0;
      bits <= '0;
    end else begin
      if (state != SHIFT) sclk <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && word_count != '0) begin
            addr <= base_addr;
            cnt  <= word_count;
          end
        end
        CAPT: begin
          sreg <= sram_q;
          div  <= '0;
          bits <= '0;
        end
        SHIFT: begin
          if (half_end) begin
            div  <= '0;
            sclk <= ~sclk;
            // the final bit stays on mosi until the next word loads
            if (sclk) begin
              bits <= bits + BIT_W'(1);
              if (!last_fall)
                sreg <= {sreg[DATA_W-2:0], 1'b0};
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        NEXT: begin
          addr <= addr + ADDR_W'(1);
          cnt  <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign sram_wen = 1'b1;
  assign sram_a   = addr;
  assign ser_clk  = sclk;
  assign ser_mosi = sreg[DATA_W-1];

endmodule

// File: tb/tb_sram_serial_streamer.sv
// Scoreboard bench for sram_serial_streamer: two instances
// (CLK_DIV=4 and CLK_DIV=1) share one behavioural SRAM image.
module tb_sram_serial_streamer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] start = '0;
  logic [3:0] base_addr = '0;
  logic [4:0] word_count = '0;

  logic [1:0] cen, wen, sclk, mosi, csn, busy, done;
  logic [1:0][3:0]  sa;
  logic [1:0][31:0] q;

  logic [31:0] mem [16];

  int total = 0;
  int bad   = 0;

  logic [31:0] expw [$];
  logic [3:0]  expa [$];

  int nb [2];
  logic [31:0] acc [2];
  int rise_cnt [2];
  int cen_cnt [2];
  int done_cnt [2];
  int low_cnt [2];
  int last_rise [2];
  logic [1:0] psclk = '0;
  int cyc = 0;

  always #5 clk = ~clk;

  sram_serial_streamer #(.CLK_DIV(4)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]),
    .base_addr(base_addr), .word_count(word_count),
    .sram_cen(cen[0]), .sram_wen(wen[0]), .sram_a(sa[0]),
    .sram_q(q[0]), .ser_clk(sclk[0]), .ser_mosi(mosi[0]),
    .ser_cs_n(csn[0]), .busy(busy[0]), .done(done[0])
  );

  sram_serial_streamer #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]),
    .base_addr(base_addr), .word_count(word_count),
    .sram_cen(cen[1]), .sram_wen(wen[1]), .sram_a(sa[1]),
    .sram_q(q[1]), .ser_clk(sclk[1]), .ser_mosi(mosi[1]),
    .ser_cs_n(csn[1]), .busy(busy[1]), .done(done[1])
  );

  // synchronous-read SRAM model
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (!cen[i] && wen[i]) q[i] <= mem[sa[i]];

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // monitor: reassembles serial words and checks SRAM reads
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        nb[i] = 0;
      end else begin
        if (!csn[i]) low_cnt[i]++;
        if (sclk[i] && !psclk[i]) begin
          rise_cnt[i]++;
          chk("cs_low_at_rise", csn[i], 0);
          if (nb[i] > 0)
            chk("sclk_period", cyc - last_rise[i],
                (i == 0) ? 8 : 2);
          last_rise[i] = cyc;
          acc[i] = {acc[i][30:0], mosi[i]};
          nb[i]++;
          if (nb[i] == 32) begin
            nb[i] = 0;
            if (expw.size() == 0)
              chk("unexpected_word", acc[i], 64'hdead);
            else
              chk("word", acc[i], expw.pop_front());
          end
        end
        if (!cen[i]) begin
          cen_cnt[i]++;
          chk("wen_high", wen[i], 1);
          if (expa.size() == 0)
            chk("unexpected_read", sa[i], 64'hdead);
          else
            chk("read_addr", sa[i], expa.pop_front());
        end
        if (busy[i]) chk("cs_low_busy", csn[i], 0);
        if (done[i]) begin
          done_cnt[i]++;
          chk("done_state", {csn[i], busy[i]}, 2'b10);
        end
      end
      psclk[i] = sclk[i];
    end
  end

  task automatic burst(input int i, input logic [3:0] ba,
                       input logic [4:0] wc);
    logic [3:0] a;
    @(negedge clk);
    base_addr = ba;
    word_count = wc;
    start[i] = 1'b1;
    for (int k = 0; k < int'(wc); k++) begin
      a = ba + 4'(k);
      expw.push_back(mem[a]);
      expa.push_back(a);
    end
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int d0,
                           input int budget, output int n);
    n = 0;
    while (done_cnt[i] == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done_cnt[i] > d0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, r0, c0, l0, n, i, wc;
    logic [3:0] b;
    for (int k = 0; k < 16; k++) mem[k] = $urandom;
    for (int k = 0; k < 2; k++) begin
      nb[k] = 0; acc[k] = '0; rise_cnt[k] = 0;
      cen_cnt[k] = 0; done_cnt[k] = 0; low_cnt[k] = 0;
      last_rise[k] = 0;
    end

    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++)
      chk("reset_outputs",
          {cen[k], wen[k], sa[k], sclk[k], mosi[k],
           csn[k], busy[k], done[k]},
          {1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // single word, CLK_DIV=4
    mem[3] = 32'hA5C3_0F81;
    d0 = done_cnt[0]; r0 = rise_cnt[0]; c0 = cen_cnt[0];
    burst(0, 4'd3, 5'd1);
    wait_done(0, d0, 2000, n);
    chk("w1_rises", rise_cnt[0] - r0, 32);
    chk("w1_reads", cen_cnt[0] - c0, 1);
    chk("w1_drained", expw.size(), 0);

    // wrapping three-word burst
    mem[14] = 32'h1111_1111;
    mem[15] = 32'h2222_2222;
    mem[0]  = 32'h3333_3333;
    repeat (3) @(negedge clk);
    d0 = done_cnt[0]; r0 = rise_cnt[0];
    burst(0, 4'd14, 5'd3);
    wait_done(0, d0, 4000, n);
    chk("w3_rises", rise_cnt[0] - r0, 96);
    chk("w3_drained", expw.size() + expa.size(), 0);

    // zero-length request
    repeat (3) @(negedge clk);
    d0 = done_cnt[0]; r0 = rise_cnt[0];
    c0 = cen_cnt[0]; l0 = low_cnt[0];
    burst(0, 4'd5, 5'd0);
    wait_done(0, d0, 10, n);
    chk("w0_latency_ok", n <= 2, 1);
    repeat (5) @(negedge clk);
    chk("w0_no_read", cen_cnt[0] - c0, 0);
    chk("w0_no_sclk", rise_cnt[0] - r0, 0);
    chk("w0_cs_high", low_cnt[0] - l0, 0);

    // start during SHIFT must be ignored
    mem[7] = $urandom; mem[8] = $urandom;
    d0 = done_cnt[0]; r0 = rise_cnt[0]; c0 = cen_cnt[0];
    burst(0, 4'd7, 5'd2);
    n = 0;
    while (rise_cnt[0] - r0 < 5 && n < 1000) begin
      @(negedge clk); n++;
    end
    base_addr = 4'd0; word_count = 5'd1; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, d0, 4000, n);
    repeat (300) @(negedge clk);
    chk("ign_done_once", done_cnt[0] - d0, 1);
    chk("ign_two_reads", cen_cnt[0] - c0, 2);
    chk("ign_rises", rise_cnt[0] - r0, 64);

    // reset mid-word
    mem[5] = $urandom;
    burst(0, 4'd5, 5'd1);
    n = 0;
    while (nb[0] < 10 && n < 1000) begin
      @(negedge clk); n++;
    end
    reset = 1'b1;
    #1;
    chk("midreset_outputs",
        {csn[0], sclk[0], busy[0], cen[0]}, 4'b1001);
    expw.delete();
    expa.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mem[9] = $urandom;
    d0 = done_cnt[0];
    burst(0, 4'd9, 5'd1);
    wait_done(0, d0, 2000, n);
    chk("post_reset_drained", expw.size(), 0);

    // CLK_DIV=1 two-word burst
    b = 4'($urandom);
    mem[b] = $urandom; mem[b + 4'd1] = $urandom;
    d0 = done_cnt[1]; r0 = rise_cnt[1]; c0 = cen_cnt[1];
    burst(1, b, 5'd2);
    wait_done(1, d0, 1000, n);
    chk("d1_reads", cen_cnt[1] - c0, 2);
    chk("d1_rises", rise_cnt[1] - r0, 64);
    chk("d1_drained", expw.size(), 0);

    // random bursts on both instances
    for (int r = 0; r < 8; r++) begin
      i = r % 2;
      b = 4'($urandom);
      wc = $urandom_range(1, 3);
      for (int k = 0; k < wc; k++) mem[b + 4'(k)] = $urandom;
      repeat (3) @(negedge clk);
      d0 = done_cnt[i];
      burst(i, b, 5'(wc));
      wait_done(i, d0, 4000, n);
    end
    repeat (5) @(negedge clk);
    chk("final_drained", expw.size() + expa.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_serial_streamer.md
Name: sram_serial_streamer

Overview:
- Read-side counterpart of the flash fetch path: the boot FSM shifts serial flash bits in and writes words into SRAM; this block reads words back out of SRAM and shifts them out on a divided serial clock.
- Presents an SPI-style transmitter with signals ser_clk, ser_mosi and ser_cs_n.
- Sits beside the SRAM macro, sharing its port through the top-level arbitration. Used for memory readback/dump and for chaining to a downstream receiver.

Parameters:
- ADDR_W, 4, SRAM address width.
- DATA_W, 32, SRAM word width and bits shifted per word.
- CNT_W, 5, word-count width; must be at least ADDR_W+1 so a full-memory dump is possible.
- CLK_DIV, 4, clk cycles per ser_clk half-period; minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first SRAM address; latched on accepted start.
- word_count  in  CNT_W  number of words to send; latched on accepted start.
- sram_cen  out  1  SRAM chip enable, active low.
- sram_wen  out  1  SRAM write enable, active low; always 1 from this block.
- sram_a  out  ADDR_W  SRAM address.
- sram_q  in  DATA_W  SRAM read data; valid the cycle after a read edge.
- ser_clk  out  1  serial clock; idles low.
- ser_mosi  out  1  serial data, MSB first.
- ser_cs_n  out  1  frame select, active low.
- busy  out  1  high from accepted start until the cycle done is high.
- done  out  1  one-cycle pulse at end of burst.

Behaviour:
- Reset values: all outputs take these values immediately on reset assert, including mid-burst. Latched address, count and shift register clear.
  - sram_cen=1, sram_wen=1, sram_a=0.
  - ser_clk=0, ser_mosi=0, ser_cs_n=1.
  - busy=0, done=0.
  - FSM=IDLE.
- FSM states: IDLE, READ, CAPT, SHIFT, NEXT, DONE.
- IDLE:
  - On start=1 with word_count≠0: latch base_addr and word_count, busy=1, go to READ.
  - On start=1 with word_count=0: go directly to DONE. No SRAM access; cs_n stays high.
- READ (1 cycle): sram_cen=0, sram_wen=1, sram_a=current address. ser_cs_n=0 from the first READ of the burst onward.
- CAPT (1 cycle): load sram_q into the DATA_W shift register; ser_mosi=bit DATA_W-1; ser_clk=0. Go to SHIFT.
- SHIFT: divider counts CLK_DIV clk cycles per half-period.
  - First half-period ends: ser_clk rises. The receiver samples ser_mosi on this edge.
  - Second half-period ends: ser_clk falls, the register shifts left, and ser_mosi takes the next bit.
  - After the DATA_W-th falling edge, go to NEXT. ser_mosi holds the last bit until the next CAPT.
  - Per word: DATA_W*2*CLK_DIV cycles in SHIFT, plus 3 overhead cycles (READ, CAPT, NEXT).
- NEXT (1 cycle): address increments modulo 2^ADDR_W (15 wraps to 0); count decrements. If the count reaches 0, go to DONE, else go to READ.
- ser_cs_n stays low across inter-word gaps. ser_clk is held low outside SHIFT.
- DONE (1 cycle): done=1, busy=0, ser_cs_n=1, sram_cen=1; then go to IDLE.
- A start asserted while not in IDLE is ignored and is not queued.
- sram_cen is low only in READ; the SRAM is otherwise free for the writer. The block issues exactly one read per word.

Test Plan:
- Preload SRAM[3]=0xA5C3_0F81; start with base_addr=3, word_count=1, CLK_DIV=4.
  - Expect cs_n low, exactly 32 ser_clk rising edges, 8 clk cycles per ser_clk period.
  - Expect the bits sampled on rising edges to reassemble to 0xA5C3_0F81.
  - Expect a done pulse, then cs_n=1.
- Start with base_addr=14, word_count=3 (SRAM[14]=0x1111_1111, SRAM[15]=0x2222_2222, SRAM[0]=0x3333_3333).
  - Expect sram_a reads in order 14, 15, 0 (wrap).
  - Expect 96 bits reassembling the three words in order, with cs_n continuously low.
- Start with word_count=0 → done high 2 cycles after start. sram_cen never asserts, ser_clk never toggles, cs_n stays 1.
- Pulse start again during SHIFT of the first word of a 2-word burst → ignored. Exactly 2 words are sent and done pulses once.
- Assert reset during bit 10 of a word → same cycle: cs_n=1, ser_clk=0, busy=0, sram_cen=1. After release, a new start=1/word_count=1 sends the correct full word.
- Set CLK_DIV=1 with word_count=2 → ser_clk period is 2 clk cycles, sram_cen asserts exactly 2 cycles total, and data matches.
